// File: rtl/semi_auto_sequencer.sv
// Semi-automatic maneuver sequencer: debounced command edges start a timed TURN/STRAIGHT run.
// Define SEMI_AUTO_TIMEOUT_EN to build the WAIT_CMD idle timeout; otherwise timeout is tied low.
module semi_auto_sequencer #(
    parameter int unsigned TURN_CYCLES     = 4,
    parameter int unsigned STRAIGHT_CYCLES = 6,
    parameter int unsigned IDLE_TIMEOUT    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       cmd_forward,
    input  logic       cmd_left,
    input  logic       cmd_right,
    input  logic       cmd_back,
    output logic       goStraight,
    output logic       goBackward,
    output logic       goLeft,
    output logic       goRight,
    output logic [2:0] state,
    output logic       busy,
    output logic       timeout
);

    localparam logic [2:0] S_IDLE     = 3'b000;
    localparam logic [2:0] S_WAIT_CMD = 3'b001;
    localparam logic [2:0] S_TURN     = 3'b010;
    localparam logic [2:0] S_STRAIGHT = 3'b011;

    // Counters hold "cycles remaining minus one", so expiry is a compare against zero.
    localparam logic [31:0] TURN_LOAD     = 32'(TURN_CYCLES - 1);
    localparam logic [31:0] BACK_LOAD     = 32'(2 * TURN_CYCLES - 1);
    localparam logic [31:0] STRAIGHT_LOAD = 32'(STRAIGHT_CYCLES - 1);
    localparam logic [31:0] IDLE_LAST     = 32'(IDLE_TIMEOUT - 1);

    logic [2:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        dir_q, dir_d;          // 1 = right, 0 = left
    logic [3:0]  btn_q, btn_d;          // {forward, left, right, back}
    logic        go_straight_q, go_straight_d;
    logic        go_left_q, go_left_d;
    logic        go_right_q, go_right_d;
    logic        busy_q, busy_d;
    logic        timeout_d;
    logic        idle_expired;
    logic [3:0]  rise;

    assign btn_d = {cmd_forward, cmd_left, cmd_right, cmd_back};
    assign rise  = btn_d & ~btn_q;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        timeout_d = 1'b0;
        if (!enable) begin
            state_d = S_IDLE;
            cnt_d   = 32'd0;
            dir_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_WAIT_CMD;
                S_WAIT_CMD: begin
                    if (rise[3]) begin
                        state_d = S_STRAIGHT;
                        cnt_d   = STRAIGHT_LOAD;
                    end else if (rise[2]) begin
                        state_d = S_TURN;
                        cnt_d   = TURN_LOAD;
                        dir_d   = 1'b0;
                    end else if (rise[1]) begin
                        state_d = S_TURN;
                        cnt_d   = TURN_LOAD;
                        dir_d   = 1'b1;
                    end else if (rise[0]) begin
                        state_d = S_TURN;
                        cnt_d   = BACK_LOAD;
                        dir_d   = 1'b0;
                    end else if (idle_expired) begin
                        state_d   = S_IDLE;
                        timeout_d = 1'b1;
                    end
                end
                S_TURN: begin
                    if (cnt_q == 32'd0) begin
                        state_d = S_STRAIGHT;
                        cnt_d   = STRAIGHT_LOAD;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                S_STRAIGHT: begin
                    if (cnt_q == 32'd0) begin
                        state_d = S_WAIT_CMD;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 32'd0;
                    dir_d   = 1'b0;
                end
            endcase
        end

        // Outputs decode the next state so they switch on the same edge as state.
        go_straight_d = (state_d == S_STRAIGHT);
        go_left_d     = (state_d == S_TURN) && !dir_d;
        go_right_d    = (state_d == S_TURN) && dir_d;
        busy_d        = (state_d == S_TURN) || (state_d == S_STRAIGHT);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= 32'd0;
            dir_q         <= 1'b0;
            btn_q         <= 4'd0;
            go_straight_q <= 1'b0;
            go_left_q     <= 1'b0;
            go_right_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dir_q         <= dir_d;
            btn_q         <= btn_d;
            go_straight_q <= go_straight_d;
            go_left_q     <= go_left_d;
            go_right_q    <= go_right_d;
            busy_q        <= busy_d;
        end
    end

`ifdef SEMI_AUTO_TIMEOUT_EN
    logic [31:0] idle_q, idle_d;
    logic        timeout_q;

    assign idle_expired = (idle_q == IDLE_LAST);

    // Counts consecutive WAIT_CMD cycles; any exit (command, disable, timeout) clears it.
    always_comb begin
        idle_d = 32'd0;
        if (state_q == S_WAIT_CMD && state_d == S_WAIT_CMD) begin
            idle_d = idle_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q    <= 32'd0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_idle_cfg;

    assign idle_expired    = 1'b0;
    assign timeout         = 1'b0;
    assign unused_idle_cfg = ^{IDLE_LAST, timeout_d};
`endif

    assign state      = state_q;
    assign goStraight = go_straight_q;
    assign goBackward = 1'b0;
    assign goLeft     = go_left_q;
    assign goRight    = go_right_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_semi_auto_sequencer.sv
// Self-checking bench for semi_auto_sequencer: directed table, hand sequences, randomized run vs model.
module tb_semi_auto_sequencer;

    localparam int unsigned TC = 4;
    localparam int unsigned SC = 6;
    localparam int unsigned IT = 10;

    localparam logic [2:0] ST_IDLE = 3'b000;
    localparam logic [2:0] ST_WAIT = 3'b001;
    localparam logic [2:0] ST_TURN = 3'b010;
    localparam logic [2:0] ST_STR  = 3'b011;

    // Move vectors {goStraight, goBackward, goLeft, goRight}
    localparam logic [3:0] MV_NONE  = 4'b0000;
    localparam logic [3:0] MV_STR   = 4'b1000;
    localparam logic [3:0] MV_LEFT  = 4'b0010;
    localparam logic [3:0] MV_RIGHT = 4'b0001;

    // Button vectors {forward, left, right, back}
    localparam logic [3:0] B_NONE  = 4'b0000;
    localparam logic [3:0] B_FWD   = 4'b1000;
    localparam logic [3:0] B_LEFT  = 4'b0100;
    localparam logic [3:0] B_RIGHT = 4'b0010;
    localparam logic [3:0] B_BACK  = 4'b0001;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] btn;
    logic       goStraight, goBackward, goLeft, goRight, busy, timeout;
    logic [2:0] state;

    always #5 clk = ~clk;

    semi_auto_sequencer #(
        .TURN_CYCLES    (TC),
        .STRAIGHT_CYCLES(SC),
        .IDLE_TIMEOUT   (IT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .cmd_forward(btn[3]),
        .cmd_left   (btn[2]),
        .cmd_right  (btn[1]),
        .cmd_back   (btn[0]),
        .goStraight (goStraight),
        .goBackward (goBackward),
        .goLeft     (goLeft),
        .goRight    (goRight),
        .state      (state),
        .busy       (busy),
        .timeout    (timeout)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Observation / expectation vector: {state[2:0], moves[3:0], busy, timeout}
    function automatic logic [8:0] observed();
        return {state, goStraight, goBackward, goLeft, goRight, busy, timeout};
    endfunction

    function automatic logic [8:0] pack_exp(input logic [2:0] st, input logic [3:0] mv, input logic to);
        return {st, mv, (st == ST_TURN) || (st == ST_STR), to};
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got state=%b mv=%b busy=%b to=%b, want state=%b mv=%b busy=%b to=%b",
                     name, $time, act[8:6], act[5:2], act[1], act[0], exp[8:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [3:0] b);
        rst    = r;
        enable = e;
        btn    = b;
        @(posedge clk);
        #1;
    endtask

    task automatic step_chk(input logic r, input logic e, input logic [3:0] b,
                            input logic [2:0] st, input logic [3:0] mv, input logic to,
                            input string name);
        step(r, e, b);
        check(name, observed(), pack_exp(st, mv, to));
    endtask

    // ---------------- behavioural reference model ----------------
    // The model keeps the expected output for the current cycle plus a queue of
    // pre-computed outputs for the rest of an accepted maneuver.
    logic [8:0] m_cur;
    logic [8:0] m_plan[$];
    logic [3:0] m_prev;
    int         m_idle;

    task automatic plan_maneuver(input logic [3:0] turn_mv, input int turn_len);
        for (int k = 0; k < turn_len; k++) m_plan.push_back(pack_exp(ST_TURN, turn_mv, 1'b0));
        for (int k = 0; k < int'(SC); k++) m_plan.push_back(pack_exp(ST_STR, MV_STR, 1'b0));
        m_plan.push_back(pack_exp(ST_WAIT, MV_NONE, 1'b0));
    endtask

    task automatic model_edge(input logic r, input logic e, input logic [3:0] b);
        logic [3:0] rise;
        rise   = b & ~m_prev;
        m_prev = r ? 4'b0000 : b;
        if (r || !e) begin
            m_cur = pack_exp(ST_IDLE, MV_NONE, 1'b0);
            m_plan.delete();
            m_idle = 0;
        end else if (m_plan.size() > 0) begin
            m_cur  = m_plan.pop_front();
            m_idle = 0;
        end else if (m_cur[8:6] != ST_WAIT) begin
            m_cur  = pack_exp(ST_WAIT, MV_NONE, 1'b0);
            m_idle = 0;
        end else if (rise != 4'b0000) begin
            if (rise[3])      plan_maneuver(MV_NONE, 0);
            else if (rise[2]) plan_maneuver(MV_LEFT, int'(TC));
            else if (rise[1]) plan_maneuver(MV_RIGHT, int'(TC));
            else              plan_maneuver(MV_LEFT, 2 * int'(TC));
            m_cur  = m_plan.pop_front();
            m_idle = 0;
        end else begin
            m_idle++;
`ifdef SEMI_AUTO_TIMEOUT_EN
            if (m_idle == int'(IT)) begin
                m_cur  = pack_exp(ST_IDLE, MV_NONE, 1'b1);
                m_idle = 0;
            end
`endif
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        rst;
        logic        en;
        logic [3:0]  btn;
        int          n;
        logic [2:0]  st;
        logic [3:0]  mv;
        string       name;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [3:0] rb;
        rst    = 1'b1;
        enable = 1'b0;
        btn    = B_NONE;

        tbl.push_back('{1'b1, 1'b1, 4'b1111, 3, ST_IDLE, MV_NONE,  "reset_all_high"});
        tbl.push_back('{1'b0, 1'b1, 4'b1111, 1, ST_WAIT, MV_NONE,  "idle_to_wait"});
        tbl.push_back('{1'b0, 1'b1, B_NONE,  2, ST_WAIT, MV_NONE,  "wait_no_cmd"});
        tbl.push_back('{1'b0, 1'b1, B_LEFT,  1, ST_TURN, MV_LEFT,  "left_edge"});
        tbl.push_back('{1'b0, 1'b1, B_NONE,  3, ST_TURN, MV_LEFT,  "left_turn"});
        tbl.push_back('{1'b0, 1'b1, B_NONE,  6, ST_STR,  MV_STR,   "left_straight"});
        tbl.push_back('{1'b0, 1'b1, B_NONE,  2, ST_WAIT, MV_NONE,  "left_done"});
        tbl.push_back('{1'b0, 1'b1, B_BACK,  1, ST_TURN, MV_LEFT,  "back_edge"});
        tbl.push_back('{1'b0, 1'b1, B_NONE,  7, ST_TURN, MV_LEFT,  "back_turn"});
        tbl.push_back('{1'b0, 1'b1, B_NONE,  6, ST_STR,  MV_STR,   "back_straight"});
        tbl.push_back('{1'b0, 1'b1, B_NONE,  1, ST_WAIT, MV_NONE,  "back_done"});
        tbl.push_back('{1'b0, 1'b1, 4'b1010, 1, ST_STR,  MV_STR,   "fwd_right_prio"});
        tbl.push_back('{1'b0, 1'b1, B_NONE,  5, ST_STR,  MV_STR,   "fwd_straight"});
        tbl.push_back('{1'b0, 1'b1, B_NONE,  1, ST_WAIT, MV_NONE,  "fwd_done"});
        tbl.push_back('{1'b0, 1'b1, 4'b0101, 1, ST_TURN, MV_LEFT,  "left_back_prio"});
        tbl.push_back('{1'b0, 1'b1, B_NONE,  3, ST_TURN, MV_LEFT,  "left_back_turn"});
        tbl.push_back('{1'b0, 1'b1, B_NONE,  6, ST_STR,  MV_STR,   "left_back_str"});
        tbl.push_back('{1'b0, 1'b1, B_NONE,  1, ST_WAIT, MV_NONE,  "left_back_done"});
        tbl.push_back('{1'b0, 1'b1, 4'b0011, 1, ST_TURN, MV_RIGHT, "right_back_prio"});
        tbl.push_back('{1'b0, 1'b1, B_NONE,  3, ST_TURN, MV_RIGHT, "right_turn"});
        tbl.push_back('{1'b0, 1'b1, B_NONE,  6, ST_STR,  MV_STR,   "right_straight"});
        tbl.push_back('{1'b0, 1'b1, B_NONE,  1, ST_WAIT, MV_NONE,  "right_done"});

        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                step_chk(tbl[i].rst, tbl[i].en, tbl[i].btn, tbl[i].st, tbl[i].mv, 1'b0, tbl[i].name);
            end
        end

        // Edge during TURN, button held through the end of the maneuver: no retrigger.
        step_chk(1'b0, 1'b1, B_LEFT, ST_TURN, MV_LEFT, 1'b0, "hold_left_edge");
        step_chk(1'b0, 1'b1, B_NONE, ST_TURN, MV_LEFT, 1'b0, "hold_turn_c2");
        for (int k = 0; k < 2; k++)  step_chk(1'b0, 1'b1, B_RIGHT, ST_TURN, MV_LEFT, 1'b0, "hold_right_turn");
        for (int k = 0; k < int'(SC); k++) step_chk(1'b0, 1'b1, B_RIGHT, ST_STR, MV_STR, 1'b0, "hold_right_str");
        for (int k = 0; k < 3; k++)  step_chk(1'b0, 1'b1, B_RIGHT, ST_WAIT, MV_NONE, 1'b0, "hold_right_wait");
        step_chk(1'b0, 1'b1, B_NONE, ST_WAIT, MV_NONE, 1'b0, "hold_released");

        // Enable dropped in STRAIGHT cycle 3; re-enable needs a fresh edge.
        step_chk(1'b0, 1'b1, B_FWD,  ST_STR,  MV_STR,  1'b0, "dis_fwd_edge");
        step_chk(1'b0, 1'b1, B_NONE, ST_STR,  MV_STR,  1'b0, "dis_str_c2");
        step_chk(1'b0, 1'b1, B_NONE, ST_STR,  MV_STR,  1'b0, "dis_str_c3");
        step_chk(1'b0, 1'b0, B_NONE, ST_IDLE, MV_NONE, 1'b0, "dis_abort");
        step_chk(1'b0, 1'b0, B_FWD,  ST_IDLE, MV_NONE, 1'b0, "dis_press_idle");
        step_chk(1'b0, 1'b1, B_FWD,  ST_WAIT, MV_NONE, 1'b0, "reen_wait");
        for (int k = 0; k < 2; k++) step_chk(1'b0, 1'b1, B_FWD, ST_WAIT, MV_NONE, 1'b0, "reen_held_no_edge");
        step_chk(1'b0, 1'b1, B_NONE, ST_WAIT, MV_NONE, 1'b0, "reen_release");
        step_chk(1'b0, 1'b1, B_FWD,  ST_STR,  MV_STR,  1'b0, "reen_new_edge");
        for (int k = 0; k < int'(SC) - 1; k++) step_chk(1'b0, 1'b1, B_NONE, ST_STR, MV_STR, 1'b0, "reen_str");
        step_chk(1'b0, 1'b1, B_NONE, ST_WAIT, MV_NONE, 1'b0, "reen_done");

        // Reset mid-maneuver, then disable colliding with a command edge.
        step_chk(1'b0, 1'b1, B_LEFT, ST_TURN, MV_LEFT, 1'b0, "rst_mid_edge");
        step_chk(1'b0, 1'b1, B_NONE, ST_TURN, MV_LEFT, 1'b0, "rst_mid_turn");
        step_chk(1'b1, 1'b1, B_LEFT, ST_IDLE, MV_NONE, 1'b0, "rst_mid_abort");
        step_chk(1'b0, 1'b1, B_NONE, ST_WAIT, MV_NONE, 1'b0, "rst_mid_recover");
        step_chk(1'b0, 1'b0, B_FWD,  ST_IDLE, MV_NONE, 1'b0, "dis_beats_cmd");
        step_chk(1'b0, 1'b1, B_NONE, ST_WAIT, MV_NONE, 1'b0, "wait_entry");

`ifdef SEMI_AUTO_TIMEOUT_EN
        for (int k = 0; k < int'(IT) - 1; k++) step_chk(1'b0, 1'b1, B_NONE, ST_WAIT, MV_NONE, 1'b0, "to_waiting");
        step_chk(1'b0, 1'b1, B_NONE, ST_IDLE, MV_NONE, 1'b1, "to_pulse");
        step_chk(1'b0, 1'b1, B_NONE, ST_WAIT, MV_NONE, 1'b0, "to_reenter");
`else
        for (int k = 0; k < 120; k++) step_chk(1'b0, 1'b1, B_NONE, ST_WAIT, MV_NONE, 1'b0, "no_timeout");
`endif

        // Randomized run against the reference model.
        m_prev = 4'b0000;
        m_idle = 0;
        step(1'b1, 1'b1, B_NONE);
        model_edge(1'b1, 1'b1, B_NONE);
        check("rand_reset", observed(), m_cur);
        rb = B_NONE;
        for (int c = 0; c < 3000; c++) begin
            logic r, e;
            r = ($urandom_range(0, 299) == 0);
            e = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 3) == 0) rb = 4'($urandom) & 4'($urandom);
            step(r, e, rb);
            model_edge(r, e, rb);
            check("rand", observed(), m_cur);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/semi_auto_sequencer.md
SEMI_AUTO_SEQUENCER -- requirements
Module: semi_auto_sequencer

Interface
REQ-001 SHALL have parameter TURN_CYCLES, default 4, meaning cycles spent in TURN for a left/right command (legal range 1 to 2^30).
REQ-002 SHALL have parameter STRAIGHT_CYCLES, default 6, meaning cycles spent in STRAIGHT per maneuver (legal range 1 to 2^31-1).
REQ-003 SHALL have parameter IDLE_TIMEOUT, default 10, meaning WAIT_CMD cycles before a timeout pulse (used only with the macro in REQ-019; legal range 1 to 2^31-1).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1, meaning semi-auto mode is selected and the vehicle is powered.
REQ-007 SHALL have ports cmd_forward, cmd_left, cmd_right, cmd_back, input, 1 each, meaning level-sensitive command buttons that are already debounced.
REQ-008 SHALL have ports goStraight, goBackward, goLeft, goRight, output, 1 each, meaning registered move signals.
REQ-009 SHALL have port state, output, 3, the registered FSM state: IDLE=000, WAIT_CMD=001, TURN=010, STRAIGHT=011.
REQ-010 SHALL have port busy, output, 1, high when state is TURN or STRAIGHT.
REQ-011 SHALL have port timeout, output, 1, a one-cycle pulse on WAIT_CMD timeout.

Function
REQ-012 SHALL detect a command as a rising edge: the button is 1 this cycle and its registered copy is 0. Button copies SHALL update every cycle in every state.
REQ-013 SHALL use these transitions:
- IDLE goes to WAIT_CMD when enable=1.
- WAIT_CMD on a forward edge goes to STRAIGHT.
- WAIT_CMD on a left or right edge goes to TURN with direction latched.
- WAIT_CMD on a back edge goes to TURN with direction left and length 2*TURN_CYCLES.
- TURN goes to STRAIGHT when the count expires.
- STRAIGHT goes to WAIT_CMD when the count expires.
REQ-014 SHALL resolve simultaneous edges in WAIT_CMD by priority forward > left > right > back; lower-priority edges are discarded.
REQ-015 SHALL ignore all command edges while in TURN or STRAIGHT. Edges are not queued, and a button held through the end of a maneuver does not retrigger.
REQ-016 SHALL control timing and outputs as follows:
- A 32-bit down-counter is loaded on entry to TURN or STRAIGHT.
- TURN lasts exactly TURN_CYCLES clock cycles, or 2*TURN_CYCLES for back; STRAIGHT lasts exactly STRAIGHT_CYCLES.
- Outputs are registered and decoded from next_state, so they change on the same edge as state; command-edge-to-output latency is 1 clock.
REQ-017 SHALL drive move outputs {goStraight,goBackward,goLeft,goRight} by state:
- IDLE and WAIT_CMD: 0000.
- TURN: 0010 for left, 0001 for right.
- STRAIGHT: 1000.
goBackward SHALL remain 0 in every state.
REQ-018 SHALL, when enable=0 in any state, go to IDLE on the next edge: move outputs 0000, counter cleared, latched direction cleared. enable=0 SHALL take priority over all other transitions, including command edges and expiry in the same cycle.

Configuration
REQ-019 SHALL gate the timeout feature with macro SEMI_AUTO_TIMEOUT_EN.
- Defined: a 32-bit idle counter runs while in WAIT_CMD. After IDLE_TIMEOUT consecutive WAIT_CMD cycles with no accepted command, timeout pulses high for 1 cycle, the FSM goes to IDLE, and on the following cycle it re-enters WAIT_CMD if enable=1.
- The idle counter clears on every entry to WAIT_CMD and on any accepted command.
- Not defined: timeout is tied to 0, no idle counter is built, and WAIT_CMD persists indefinitely.

Reset
REQ-020 SHALL, while rst=1, set the following on the next edge, taking priority over enable and all commands:
- state = IDLE.
- All move outputs, busy and timeout = 0.
- All counters, button copies and the latched direction = 0.
REQ-021 SHALL abort any maneuver in progress when rst is asserted mid-maneuver, with no residual output after the edge.

Verification (TURN_CYCLES=4, STRAIGHT_CYCLES=6, IDLE_TIMEOUT=10)
REQ-022 SHALL cover: rst=1 with enable=1 and all buttons=1 -> state=000, move outputs 0000, busy=0 on every cycle while rst=1.
REQ-023 SHALL cover: a cmd_left pulse in WAIT_CMD -> goLeft=1 for exactly 4 cycles, then goStraight=1 for exactly 6 cycles, then state=001 with outputs 0000.
REQ-024 SHALL cover: cmd_back pulse -> goLeft=1 for 8 cycles, then goStraight=1 for 6 cycles. Separately, cmd_forward and cmd_right rising on the same cycle -> direct STRAIGHT for 6 cycles with goRight never 1.
REQ-025 SHALL cover: cmd_right edge at cycle 2 of TURN, and cmd_right held high until after return to WAIT_CMD -> no second maneuver occurs.
REQ-026 SHALL cover: enable dropped at cycle 3 of STRAIGHT -> next edge state=000 and outputs 0000; re-enabling then requires a new command edge.
REQ-027 SHALL cover, with SEMI_AUTO_TIMEOUT_EN defined: 10 idle cycles in WAIT_CMD -> timeout=1 for 1 cycle, state 000 then 001. Undefined: timeout stays 0 for more than 100 cycles.
